// File: rtl/prga_if.sv
// prga_if: start handshake plus the S, CT and PT memory ports of the ARC4 keystream engine.
// The slave side is the engine itself. The master side is the controller together with the memories.
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// prga: ARC4 keystream generator and decryptor. It reads length-prefixed ciphertext from CT and
// writes length-prefixed plaintext to PT, swapping S in place. One byte takes six states.
module prga (
  input  logic  clk,
  input  logic  rst,
  prga_if.slave bus
);

  // state  | meaning
  // IDLE   | rdy=1, waiting for en
  // RD_LEN | present ct_addr 0
  // LEN    | latch L, write it to pt[0]
  // RD_SI  | advance i, read s[i]
  // RD_SJ  | latch si, advance j, read s[j]
  // WR_SI  | latch sj, write s[i]=sj
  // WR_SJ  | write s[j]=si
  // RD_PAD | read s[si+sj] and ct[k]
  // WR_PT  | write pt[k] = pad ^ ct[k], loop or finish
  typedef enum logic [3:0] {
    IDLE, RD_LEN, LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  // Read data is consumed in the cycle it arrives. The port outputs therefore decode state_q
  // and the read data combinationally, and they go to zero with the asynchronous reset.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (bus.en) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
          state_d = RD_LEN;
        end
      end
      RD_LEN: begin
        ct_addr = 8'd0;
        state_d = LEN;
      end
      LEN: begin
        len_d     = bus.ct_rddata;
        pt_addr   = 8'd0;
        pt_wrdata = bus.ct_rddata;
        pt_wren   = 1'b1;
        k_d       = 8'd1;
        state_d   = (bus.ct_rddata == 8'd0) ? IDLE : RD_SI;
      end
      RD_SI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        si_d    = bus.s_rddata;
        j_d     = j_q + bus.s_rddata;
        s_addr  = j_q + bus.s_rddata;
        state_d = WR_SI;
      end
      WR_SI: begin
        sj_d     = bus.s_rddata;
        s_addr   = i_q;
        s_wrdata = bus.s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_SJ;
      end
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = RD_PAD;
      end
      RD_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = WR_PT;
      end
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = bus.s_rddata ^ bus.ct_rddata;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  assign bus.rdy       = rdy;
  assign bus.s_addr    = s_addr;
  assign bus.s_wrdata  = s_wrdata;
  assign bus.s_wren    = s_wren;
  assign bus.ct_addr   = ct_addr;
  assign bus.pt_addr   = pt_addr;
  assign bus.pt_wrdata = pt_wrdata;
  assign bus.pt_wren   = pt_wren;

endmodule

// File: tb/tb_prga.sv
// tb_prga: bench for prga with S/CT/PT memory models, a PT-write scoreboard and a reference ARC4 model.
module tb_prga;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prga_if bus();
  prga dut (.clk(clk), .rst(rst), .bus(bus));

  // memory models: 1-cycle read latency; the bench preloads them through the ld_* port
  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       ld_we;
  logic [7:0] ld_addr, ld_s, ld_ct, ld_pt;

  always @(posedge clk) begin
    if (ld_we) begin
      s_mem[ld_addr]  <= ld_s;
      ct_mem[ld_addr] <= ld_ct;
      pt_mem[ld_addr] <= ld_pt;
    end else begin
      if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
      if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
  end

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } pw_t;
  typedef struct { int len; logic [3:0][7:0] ct; logic [3:0][7:0] pt; int rdy_cyc; } vec_t;

  pw_t        exp_q [$];
  vec_t       vecs [4];
  logic [7:0] img_s [256];
  logic [7:0] img_ct [256];
  logic [7:0] m_s [256];
  logic [7:0] m_pt [256];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc, s_wr_cnt, pt_wr_cnt, rdy_rise, first_rdy;
  logic rdy_prev;

  task automatic check(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL case%0d %s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  // Textbook ARC4 PRGA over img_s/img_ct, giving the expected PT image and final S.
  task automatic rc4_model(input int len);
    logic [7:0] i, j, t;
    for (int a = 0; a < 256; a++) m_s[a] = img_s[a];
    i = 0; j = 0;
    m_pt[0] = len[7:0];
    for (int n = 1; n <= len; n++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      t = m_s[i] + m_s[j];
      m_pt[n] = img_ct[n] ^ m_s[t];
    end
  endtask

  // Identity S, CT = len then ct4 bytes; bytes past L are filler so a stray read shows up.
  task automatic prep(input int len, input logic [3:0][7:0] ct4);
    for (int a = 0; a < 256; a++) begin
      img_s[a] = a[7:0];
      if (a == 0)                 img_ct[a] = len[7:0];
      else if (a < 4 && a <= len) img_ct[a] = ct4[a];
      else if (len == 255)        img_ct[a] = 8'h00;
      else                        img_ct[a] = 8'h5A;
    end
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_addr = a[7:0]; ld_s = img_s[a]; ld_ct = img_ct[a]; ld_pt = 8'hEE;
    end
    @(negedge clk);
    ld_we = 1'b0;
    rc4_model(len);
  endtask

  task automatic step();
    pw_t e;
    @(negedge clk);
    cyc++;
    if (bus.pt_wren) begin
      pt_wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pt_extra_write: got write addr 0x%0h data 0x%0h at cycle %0d, expected none",
                 bus.pt_addr, bus.pt_wrdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check(cyc, "pt_addr", {24'd0, bus.pt_addr}, {24'd0, e.addr});
        check(cyc, "pt_wrdata", {24'd0, bus.pt_wrdata}, {24'd0, e.data});
      end
    end
    if (bus.s_wren) s_wr_cnt++;
    if (bus.rdy && !rdy_prev) begin
      rdy_rise++;
      if (first_rdy < 0) first_rdy = cyc;
    end
    rdy_prev = bus.rdy;
  endtask

  task automatic begin_run();
    @(negedge clk);
    bus.en = 1'b1;
    cyc = 0; rdy_prev = 1'b1; rdy_rise = 0; first_rdy = -1; s_wr_cnt = 0; pt_wr_cnt = 0;
  endtask

  // mode 0: single en pulse. mode 1: en held through cycle 8 and re-pulsed at 12 while busy.
  task automatic run_case(input int tag, input int len, input int exp_rdy, input int mode);
    int   budget;
    int   bad;
    budget = 6 * len + 12;
    begin_run();
    while (cyc < budget && (mode == 1 || first_rdy < 0)) begin
      step();
      bus.en = (mode == 1) ? ((cyc < 8) || (cyc == 11)) : 1'b0;
    end
    bus.en = 1'b0;
    check(tag, "rdy_return_cycle", first_rdy, exp_rdy);
    check(tag, "rdy_rise_count", rdy_rise, 1);
    check(tag, "pt_write_count", pt_wr_cnt, len + 1);
    check(tag, "s_write_count", s_wr_cnt, 2 * len);
    check(tag, "pt_writes_missing", exp_q.size(), 0);
    exp_q.delete();
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
    check(tag, "s_final_mismatch_count", bad, 0);
    if (len < 255) check(tag, "pt_past_end_untouched", {24'd0, pt_mem[len + 1]}, 32'hEE);
  endtask

  initial begin
    bus.en = 1'b0;
    ld_we = 1'b0; ld_addr = 8'd0; ld_s = 8'd0; ld_ct = 8'd0; ld_pt = 8'd0;
    vecs[0] = '{len: 0, ct: 32'h0000_0000, pt: 32'h0000_0000, rdy_cyc: 3};
    vecs[1] = '{len: 1, ct: 32'h0000_4101, pt: 32'h0000_4301, rdy_cyc: 9};
    vecs[2] = '{len: 2, ct: 32'h0000_0002, pt: 32'h0005_0202, rdy_cyc: 15};
    vecs[3] = '{len: 3, ct: 32'h0000_0003, pt: 32'h0705_0203, rdy_cyc: 21};

    repeat (2) @(negedge clk);
    check(0, "reset_rdy", {31'd0, bus.rdy}, 1);
    check(0, "reset_s_wren", {31'd0, bus.s_wren}, 0);
    check(0, "reset_pt_wren", {31'd0, bus.pt_wren}, 0);
    check(0, "reset_addrs", {bus.s_addr, bus.ct_addr, bus.pt_addr}, 0);
    check(0, "reset_wrdata", {bus.s_wrdata, bus.pt_wrdata}, 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      prep(vecs[v].len, vecs[v].ct);
      for (int n = 0; n <= vecs[v].len; n++)
        exp_q.push_back('{addr: n[7:0], data: vecs[v].pt[n]});
      run_case(v + 1, vecs[v].len, vecs[v].rdy_cyc, 0);
    end

    // L=255 over identity S, keystream against the reference model
    prep(255, 32'h0000_00FF);
    for (int n = 0; n <= 255; n++) exp_q.push_back('{addr: n[7:0], data: m_pt[n]});
    run_case(4, 255, 1533, 0);

    // en held and re-pulsed while busy: one run only
    prep(2, vecs[2].ct);
    for (int n = 0; n <= 2; n++) exp_q.push_back('{addr: n[7:0], data: vecs[2].pt[n]});
    run_case(5, 2, 15, 1);

    // reset during the first swap write, then a clean rerun
    prep(2, vecs[2].ct);
    for (int n = 0; n <= 2; n++) exp_q.push_back('{addr: n[7:0], data: vecs[2].pt[n]});
    begin_run();
    while (cyc < 5) begin
      step();
      bus.en = 1'b0;
    end
    check(6, "swap_write_before_reset", {31'd0, bus.s_wren}, 1);
    #1 rst = 1'b1;
    #1;
    check(6, "rst_rdy_immediate", {31'd0, bus.rdy}, 1);
    check(6, "rst_s_wren_immediate", {31'd0, bus.s_wren}, 0);
    check(6, "rst_pt_wren_immediate", {31'd0, bus.pt_wren}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prep(2, vecs[2].ct);
    for (int n = 0; n <= 2; n++) exp_q.push_back('{addr: n[7:0], data: vecs[2].pt[n]});
    run_case(6, 2, 15, 0);
    check(6, "s2_after_rerun", {24'd0, s_mem[2]}, 32'h03);
    check(6, "s3_after_rerun", {24'd0, s_mem[3]}, 32'h02);
    check(6, "pt2_after_rerun", {24'd0, pt_mem[2]}, 32'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
